// File: rtl/core_wbu_top.sv
// core_wbu_top: write-back unit arbitrating EXU and LSU results into one
// register-file write port, with load extraction/extension and misalign detect.
// Optional performance counters are enabled by defining WBU_PERF_CNT_EN.
`timescale 1ns/1ps

module core_wbu_top #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned RIDX_W = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wbu_exu_valid,
  output logic              wbu_exu_ready,
  input  logic [XLEN-1:0]   wbu_exu_data,
  input  logic [RIDX_W-1:0] wbu_exu_rd_idx,
  input  logic              wbu_lsu_valid,
  output logic              wbu_lsu_ready,
  input  logic [XLEN-1:0]   wbu_lsu_data,
  input  logic [RIDX_W-1:0] wbu_lsu_rd_idx,
  input  logic [2:0]        wbu_lsu_func3,
  input  logic [1:0]        wbu_lsu_addr_lo,
  output logic              wbu_rf_wen,
  output logic [RIDX_W-1:0] wbu_rf_waddr,
  output logic [XLEN-1:0]   wbu_rf_wdata,
  output logic              wbu_err_misalign
`ifdef WBU_PERF_CNT_EN
  ,
  output logic [31:0]       wbu_cnt_exu,
  output logic [31:0]       wbu_cnt_lsu,
  output logic [31:0]       wbu_cnt_stall
`endif
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned CNT_W  = 32;

  // last_grant encoding
  localparam logic GNT_EXU = 1'b0;
  localparam logic GNT_LSU = 1'b1;

  // load types
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic              last_grant_q, last_grant_d;
  logic              rf_wen_q, rf_wen_d;
  logic [RIDX_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
  logic              err_q, err_d;

  logic              grant_exu_c;
  logic              grant_lsu_c;
  logic [BYTE_W-1:0] ld_byte;
  logic [HALF_W-1:0] ld_half;
  logic [XLEN-1:0]   ld_val;
  logic              ld_bad;

  // Round-robin arbitration: on a tie the source not granted last time wins.
  always_comb begin
    grant_lsu_c = wbu_lsu_valid && (!wbu_exu_valid || (last_grant_q == GNT_EXU));
    grant_exu_c = wbu_exu_valid && !grant_lsu_c;
  end

  assign wbu_exu_ready = grant_exu_c;
  assign wbu_lsu_ready = grant_lsu_c;

  // Load lane selection, extension and alignment/func3 legality check.
  always_comb begin
    ld_byte = '0;
    ld_val  = '0;
    ld_bad  = 1'b0;
    case (wbu_lsu_addr_lo)
      2'd0:    ld_byte = wbu_lsu_data[7:0];
      2'd1:    ld_byte = wbu_lsu_data[15:8];
      2'd2:    ld_byte = wbu_lsu_data[23:16];
      default: ld_byte = wbu_lsu_data[31:24];
    endcase
    ld_half = wbu_lsu_addr_lo[1] ? wbu_lsu_data[31:16] : wbu_lsu_data[15:0];
    case (wbu_lsu_func3)
      F3_LB:  ld_val = {{(XLEN-BYTE_W){ld_byte[BYTE_W-1]}}, ld_byte};
      F3_LBU: ld_val = {{(XLEN-BYTE_W){1'b0}}, ld_byte};
      F3_LH: begin
        ld_val = {{(XLEN-HALF_W){ld_half[HALF_W-1]}}, ld_half};
        ld_bad = wbu_lsu_addr_lo[0];
      end
      F3_LHU: begin
        ld_val = {{(XLEN-HALF_W){1'b0}}, ld_half};
        ld_bad = wbu_lsu_addr_lo[0];
      end
      F3_LW: begin
        ld_val = wbu_lsu_data;
        ld_bad = (wbu_lsu_addr_lo != 2'b00);
      end
      default: begin
        ld_val = wbu_lsu_data;
        ld_bad = 1'b1;
      end
    endcase
  end

  // Next write-port state from the granted source; x0 and bad loads never write.
  always_comb begin
    last_grant_d = last_grant_q;
    rf_wen_d     = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    err_d        = 1'b0;
    if (grant_exu_c) begin
      last_grant_d = GNT_EXU;
      rf_waddr_d   = wbu_exu_rd_idx;
      rf_wdata_d   = wbu_exu_data;
      rf_wen_d     = (wbu_exu_rd_idx != '0);
    end else if (grant_lsu_c) begin
      last_grant_d = GNT_LSU;
      rf_waddr_d   = wbu_lsu_rd_idx;
      rf_wdata_d   = ld_val;
      rf_wen_d     = !ld_bad && (wbu_lsu_rd_idx != '0);
      err_d        = ld_bad;
    end
  end

  // Write-port and arbitration state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant_q <= GNT_EXU;
      rf_wen_q     <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_wen_q     <= rf_wen_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      err_q        <= err_d;
    end
  end

  assign wbu_rf_wen       = rf_wen_q;
  assign wbu_rf_waddr     = rf_waddr_q;
  assign wbu_rf_wdata     = rf_wdata_q;
  assign wbu_err_misalign = err_q;

`ifdef WBU_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_exu_q, cnt_exu_d;
  logic [CNT_W-1:0] cnt_lsu_q, cnt_lsu_d;
  logic [CNT_W-1:0] cnt_stall_q, cnt_stall_d;

  // Transfer counters per source; a stall is a cycle with a valid but ungranted source.
  always_comb begin
    cnt_exu_d   = cnt_exu_q + CNT_W'(grant_exu_c);
    cnt_lsu_d   = cnt_lsu_q + CNT_W'(grant_lsu_c);
    cnt_stall_d = cnt_stall_q + CNT_W'(wbu_exu_valid && wbu_lsu_valid);
  end

  // Counter registers, wrapping naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_exu_q   <= '0;
      cnt_lsu_q   <= '0;
      cnt_stall_q <= '0;
    end else begin
      cnt_exu_q   <= cnt_exu_d;
      cnt_lsu_q   <= cnt_lsu_d;
      cnt_stall_q <= cnt_stall_d;
    end
  end

  assign wbu_cnt_exu   = cnt_exu_q;
  assign wbu_cnt_lsu   = cnt_lsu_q;
  assign wbu_cnt_stall = cnt_stall_q;
`endif

endmodule

// File: doc/core_wbu_top.md
Name: core_wbu_top

Overview:
Write-back unit between the execute stages (EXU for ALU results, LSU for load results) and the integer register file. It accepts one result per cycle from either source through valid/ready handshakes, with round-robin arbitration when both are valid. Load data is extracted, extended and alignment-checked here. Each accepted result produces one registered register-file write port cycle, and writes to x0 are suppressed.

Parameters:
XLEN, 32, data width of results and register-file write data.
RIDX_W, 5, register index width.

Ports:
clk  input  1  core clock.
rstn  input  1  reset, asynchronous, active-low.
wbu_exu_valid  input  1  EXU result valid.
wbu_exu_ready  output  1  EXU result accepted this cycle.
wbu_exu_data  input  XLEN  ALU result.
wbu_exu_rd_idx  input  RIDX_W  destination register.
wbu_lsu_valid  input  1  LSU load result valid.
wbu_lsu_ready  output  1  LSU result accepted this cycle.
wbu_lsu_data  input  XLEN  raw 32-bit bus read word.
wbu_lsu_rd_idx  input  RIDX_W  destination register.
wbu_lsu_func3  input  3  load type (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu).
wbu_lsu_addr_lo  input  2  load address bits [1:0].
wbu_rf_wen  output  1  register-file write enable, one-cycle pulse.
wbu_rf_waddr  output  RIDX_W  register-file write index.
wbu_rf_wdata  output  XLEN  register-file write data.
wbu_err_misalign  output  1  one-cycle pulse on a misaligned or illegal-func3 load.

Behaviour:
- Reset (async, rstn low): wbu_rf_wen=0, wbu_rf_waddr=0, wbu_rf_wdata=0, wbu_err_misalign=0, last_grant=EXU (so LSU wins the first tie). Ready outputs are combinational and therefore 0 while no source is valid.
- Arbitration (combinational), one grant per cycle:
  - Only one source valid: that source is granted.
  - Both valid: grant the source not named by last_grant.
  - last_grant updates at the clock edge on any grant.
- wbu_exu_ready = grant_exu and wbu_lsu_ready = grant_lsu. Ready depends on valid, so upstream must not make valid depend on ready.
- A non-granted source holds valid and its payload stable. Withdrawing valid while waiting is not allowed.
- Latency: a transfer accepted at edge N drives wbu_rf_wen=1 with the registered waddr/wdata during cycle N+1. With no transfer at edge N+1, wbu_rf_wen returns to 0. Back-to-back transfers give continuous wen=1. Throughput is 1 result per cycle.
- rd_idx==0: the handshake completes normally, but wbu_rf_wen stays 0. wdata/waddr may update.
- Load extension, selected by wbu_lsu_func3 and wbu_lsu_addr_lo:
  - lb/lbu: byte = data[8*addr_lo +: 8]; lb sign-extends, lbu zero-extends.
  - lh/lhu: half = data[16*addr_lo[1] +: 16]; lh sign-extends, lhu zero-extends.
  - lw: whole word.
- Misalign/illegal load: lh/lhu with addr_lo[0]=1, lw with addr_lo!=0, or func3 in {011,110,111}.
  - The transfer is still accepted.
  - wbu_rf_wen stays 0 in cycle N+1.
  - wbu_err_misalign=1 in cycle N+1 for one cycle.
- EXU data is passed through unmodified.
- Reset asserted mid-operation: all registered outputs clear immediately and any pending write is dropped.

Optional Feature:
Macro WBU_PERF_CNT_EN.
- Defined: adds outputs wbu_cnt_exu and wbu_cnt_lsu (32 bits each, reset 0).
  - Each increments by 1 on every accepted transfer from its source, including rd=0 and misaligned transfers.
  - Each wraps from 0xFFFFFFFF to 0.
  - Also adds wbu_cnt_stall (32 bits), which increments each cycle in which exactly one source is valid but not granted (a both-valid cycle counts once).
- Not defined: these ports and registers do not exist, and all other behaviour is identical.

Test Plan:
- Reset, then EXU valid with data=0x1234_5678 and rd=5 for one cycle → exu_ready=1 that cycle; next cycle rf_wen=1, waddr=5, wdata=0x12345678; the following cycle rf_wen=0.
- EXU and LSU both valid for 4 cycles starting after reset → grants in order LSU, EXU, LSU, EXU; rf_wen=1 on 4 consecutive cycles and each waddr matches its source.
- LSU data=0x80FF_7F01 with rd=3:
  - func3=000, addr_lo=1 → wdata=0x0000007F.
  - func3=000, addr_lo=3 → wdata=0xFFFFFF80.
  - func3=101, addr_lo=2 → wdata=0x000080FF.
  - func3=001, addr_lo=2 → wdata=0xFFFF80FF.
- LSU lw with addr_lo=2 (and, separately, func3=011) → lsu_ready=1; next cycle rf_wen=0 and err_misalign=1 for exactly one cycle.
- EXU rd=0 with data=0xDEADBEEF → handshake completes, rf_wen stays 0, err_misalign=0.
- Back-to-back EXU stream with rstn pulsed low mid-stream → rf_wen drops to 0 asynchronously; after release the first grant on a tie goes to LSU. With WBU_PERF_CNT_EN, counters read 0 after reset and increment by 1 per accepted transfer.
